// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: random-delay lights-out and driver reaction timer with jump-start detection.
// Define F1_TIMER_FIXED_DELAY_EN to load FIXED_DELAY instead of the LFSR value.
module f1_reaction_timer #(
  parameter int         CNT_W       = 16,
  parameter logic [6:0] FIXED_DELAY = 7'd10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [7:0]       lights,
  input  logic             btn,
  output logic             lights_off,
  output logic [CNT_W-1:0] react_cnt,
  output logic             valid,
  output logic             jump_start,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, DELAY, TIMING, DONE} state_t;
  state_t           state, state_n;
  logic [6:0]       lfsr, delay_cnt, delay_cnt_n, load_val;
  logic [CNT_W-1:0] rcnt, rcnt_n, react_cnt_n;
  logic             btn_q, press, lights_off_n, valid_n, jump_start_n;
  assign press = btn & ~btn_q;
`ifdef F1_TIMER_FIXED_DELAY_EN
  assign load_val = FIXED_DELAY;
`else
  assign load_val = lfsr;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= 7'h01;
      btn_q      <= 1'b0;
      delay_cnt  <= '0;
      rcnt       <= '0;
      react_cnt  <= '0;
      lights_off <= 1'b0;
      valid      <= 1'b0;
      jump_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      lfsr       <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      btn_q      <= btn;
      delay_cnt  <= delay_cnt_n;
      rcnt       <= rcnt_n;
      react_cnt  <= react_cnt_n;
      lights_off <= lights_off_n;
      valid      <= valid_n;
      jump_start <= jump_start_n;
      busy       <= (state_n == DELAY) || (state_n == TIMING);
    end
  end
  // A press always takes priority over a tick arriving in the same cycle.
  always_comb begin
    state_n      = state;
    delay_cnt_n  = delay_cnt;
    rcnt_n       = rcnt;
    react_cnt_n  = react_cnt;
    lights_off_n = lights_off;
    valid_n      = 1'b0;
    jump_start_n = jump_start;
    case (state)
      IDLE: if (lights == 8'hFF) begin
        state_n     = DELAY;
        delay_cnt_n = load_val;
      end
      DELAY: if (press) begin
        valid_n      = 1'b1;
        jump_start_n = 1'b1;
        react_cnt_n  = '0;
        state_n      = DONE;
      end else if (tick) begin
        delay_cnt_n = delay_cnt - 7'd1;
        if (delay_cnt == 7'd1) begin
          state_n      = TIMING;
          lights_off_n = 1'b1;
          rcnt_n       = '0;
        end
      end
      TIMING: if (press) begin
        react_cnt_n  = rcnt;
        jump_start_n = 1'b0;
        valid_n      = 1'b1;
        state_n      = DONE;
      end else if (tick && rcnt != '1) begin
        rcnt_n = rcnt + CNT_W'(1);
      end
      DONE: if (lights == 8'h00) begin
        lights_off_n = 1'b0;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb_f1_reaction_timer: randomized run of f1_reaction_timer against a phase/countdown reference model.
module tb_f1_reaction_timer;
  localparam int CW = 4;
  localparam logic [6:0] FD = 7'd10;
  logic          clk = 1'b0, rst = 1'b1, tick = 1'b0, btn = 1'b0;
  logic [7:0]    lights = 8'h00;
  logic          lights_off, valid, jump_start, busy;
  logic [CW-1:0] react_cnt;
  int checks = 0, errors = 0;
  int seq[127];
  int phase, left, elapsed, idx, m_rc;
  bit prev_btn, m_lo, m_vld, m_js, m_bsy;
  f1_reaction_timer #(.CNT_W(CW), .FIXED_DELAY(FD)) dut (
    .clk(clk), .rst(rst), .tick(tick), .lights(lights), .btn(btn),
    .lights_off(lights_off), .react_cnt(react_cnt), .valid(valid),
    .jump_start(jump_start), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int delay_for(input int lfsr_val);
`ifdef F1_TIMER_FIXED_DELAY_EN
    return int'(FD);
`else
    return lfsr_val;
`endif
  endfunction
  // phase: 0 waiting for full bar, 1 counting down to lights-out, 2 timing driver, 3 result shown
  task automatic model_step();
    bit press;
    if (rst) begin
      phase = 0; left = 0; elapsed = 0; idx = 0; prev_btn = 0;
      m_lo = 0; m_vld = 0; m_js = 0; m_rc = 0; m_bsy = 0;
      return;
    end
    press = btn && !prev_btn;
    prev_btn = btn;
    m_vld = 0;
    if (phase == 0) begin
      if (lights == 8'hFF) begin left = delay_for(seq[idx % 127]); phase = 1; end
    end else if (phase == 1) begin
      if (press) begin m_vld = 1; m_js = 1; m_rc = 0; phase = 3; end
      else if (tick) begin
        left--;
        if (left == 0) begin phase = 2; m_lo = 1; elapsed = 0; end
      end
    end else if (phase == 2) begin
      if (press) begin
        m_vld = 1; m_js = 0; phase = 3;
        m_rc = (elapsed > (1 << CW) - 1) ? (1 << CW) - 1 : elapsed;
      end else if (tick) elapsed++;
    end else if (lights == 8'h00) begin
      m_lo = 0; phase = 0;
    end
    m_bsy = (phase == 1) || (phase == 2);
    idx++;
  endtask
  initial begin
    int v;
    v = 1;
    for (int i = 0; i < 127; i++) begin
      seq[i] = v;
      v = ((v << 1) | (((v >> 6) ^ (v >> 5)) & 1)) & 127;
    end
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("lfsr", int'(dut.lfsr), seq[idx % 127]);
      check("lights_off", int'(lights_off), int'(m_lo));
      check("valid", int'(valid), int'(m_vld));
      check("jump_start", int'(jump_start), int'(m_js));
      check("react_cnt", int'(react_cnt), m_rc);
      check("busy", int'(busy), int'(m_bsy));
      if (cyc < 2) rst = 1'b1;
      else if (cyc < 12) begin rst = 1'b0; lights = 8'h00; end
      else begin
        rst = ($urandom_range(0, 799) == 0);
        tick = ($urandom_range(0, 1) == 0);
        if ($urandom_range(0, 39) == 0) btn = ~btn;
        if ($urandom_range(0, 29) == 0) begin
          v = $urandom_range(0, 3);
          lights = (v == 0) ? 8'h00 : (v == 1) ? 8'hFF : 8'($urandom);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/f1_reaction_timer.md
# f1_reaction_timer

Downstream stage of the F1 start-light sequence FSM. It watches the 8-bit light-bar pattern. When all eight lights are lit, it waits a pseudo-random number of time-base ticks and then signals lights-out. It then measures the driver's reaction time in ticks until the button is pressed, and flags a jump start if the button is pressed before lights-out.

## Interface
Parameters:
- `CNT_W`, default 16: width of the reaction counter and of `react_cnt`.
- `FIXED_DELAY`, default 7'd10: delay in ticks used only when `F1_TIMER_FIXED_DELAY_EN` is defined; must be nonzero.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `tick`  in  1: time-base strobe from the upstream prescaler; one `clk` cycle wide.
- `lights`  in  8: light-bar pattern from the start-light FSM.
- `btn`  in  1: driver button, level-sensitive, already synchronised to `clk`.
- `lights_off`  out  1: high from lights-out until the result is taken.
- `react_cnt`  out  CNT_W: latched reaction time in ticks.
- `valid`  out  1: one-cycle pulse when `react_cnt` and `jump_start` update.
- `jump_start`  out  1: set with `valid` if the button was pressed before lights-out.
- `busy`  out  1: high in DELAY and TIMING.

## Operation
- Button edge detect:
  - `btn_q` registers `btn`; reset value 0.
  - `press = btn & ~btn_q`.
  - A held button never produces a second press.
- LFSR:
  - 7-bit, free-running, advances every `clk` cycle, including in IDLE.
  - Shift left; new bit0 = q[6] ^ q[5] (x^7+x^6+1, period 127).
  - Reset value 7'h01. All-zero is unreachable.
  - Sequence after reset: 01, 02, 04, 08, 10, 20, 41, 03, …
- States IDLE, DELAY, TIMING, DONE. Reset state is IDLE.
- IDLE:
  - When `lights == 8'hFF`, load `delay_cnt` with the current LFSR value and go to DELAY.
  - Otherwise stay in IDLE.
- DELAY:
  - On `tick`, decrement `delay_cnt`.
  - On the tick that takes `delay_cnt` from 1 to 0, go to TIMING, set `lights_off` = 1, and clear `rcnt`.
  - On `press`: pulse `valid`, set `jump_start` = 1, set `react_cnt` = 0, and go to DONE. `lights_off` stays 0.
- TIMING:
  - On `tick`, `rcnt` increments, saturating at all-ones; it never wraps.
  - On `press`: `react_cnt` <= `rcnt`, `jump_start` <= 0, pulse `valid`, go to DONE.
- DONE:
  - Hold `react_cnt`, `jump_start` and `lights_off`.
  - When `lights == 8'h00` (upstream back at its first state), clear `lights_off` and go to IDLE.
- Simultaneous events:
  - `press` and the final `tick` in the same DELAY cycle: the press wins and is a jump start.
  - `press` and `tick` in the same TIMING cycle: the press wins, `react_cnt` = `rcnt` before increment, and the tick is dropped.
- Reset in any state:
  - State = IDLE; `lights_off` = 0, `valid` = 0, `jump_start` = 0, `react_cnt` = 0, `busy` = 0.
  - LFSR = 7'h01, `btn_q` = 0, `delay_cnt` = 0, `rcnt` = 0.
- `lights` patterns other than FF and 00 are ignored in all states.

## Timing
- All outputs are registered.
- Lights-out: `lights_off` rises on the `clk` edge that consumes the N-th `tick` in DELAY, where N is the loaded delay.
- Result: `valid` is high for exactly the one cycle after the edge that samples `press`.
- `react_cnt` and `jump_start` change on that same edge and hold until the next `valid` or reset.
- IDLE to DELAY: one cycle after `lights` first equals FF.
- A `tick` arriving in the cycle of the IDLE to DELAY transition is not counted.

## Configuration
- `F1_TIMER_FIXED_DELAY_EN` defined: IDLE loads `delay_cnt` with `FIXED_DELAY`. The LFSR is still present and running, but unused.
- Not defined: IDLE loads `delay_cnt` from the LFSR (default build).

## Test plan
- LFSR after reset: hold `lights` = 00 and sample internal `lfsr` for 8 cycles -> 01, 02, 04, 08, 10, 20, 41, 03.
- Normal run, fixed delay, FIXED_DELAY=10:
  - Stimulus: `lights` = FF, then 10 ticks, then 5 more ticks, then press `btn`.
  - Required: `lights_off` rises on the 10th tick; `valid` pulses once with `react_cnt` = 5 and `jump_start` = 0.
- Jump start, fixed delay, FIXED_DELAY=10: `lights` = FF, 3 ticks, press `btn` -> `valid` pulses, `jump_start` = 1, `react_cnt` = 0, `lights_off` stays 0.
- Simultaneous press and tick in TIMING after 7 counted ticks -> `react_cnt` = 7, not 8.
- Saturation with CNT_W=4: no press for 20 ticks in TIMING, then press -> `react_cnt` = 15.
- Reset mid-TIMING:
  - Assert `rst` for 1 cycle -> all outputs 0 and state IDLE.
  - Then `lights` 00 -> FF -> the run restarts, with the delay loaded from the LFSR sequence restarted at 01.
